fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ptr_sync.sv | 30 +++
 rtl/fifo_read_ctrl.sv | 89 ++++++++
 tb/tb_fifo_read_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and Gray/binary pointer conversion, used by both clock domains.
// Functions work on a fixed wide vector; callers zero-extend in and size-cast out.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_PTR_WIDTH  = 4;
  localparam int FIFO_GRAY_W     = 32;

  function automatic logic [FIFO_GRAY_W-1:0] bin2gray(input logic [FIFO_GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended input keeps the upper result bits zero, so truncation is exact.
  function automatic logic [FIFO_GRAY_W-1:0] gray2bin(input logic [FIFO_GRAY_W-1:0] g);
    logic [FIFO_GRAY_W-1:0] b;
    b[FIFO_GRAY_W-1] = g[FIFO_GRAY_W-1];
    for (int i = FIFO_GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into w_clk.
// Latency STAGES edges; no backpressure.
module fifo_ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             w_clk,
  input  logic             wresetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side pointer/flag control; read strobe combinational, flags registered one edge later.
// Reads are suppressed while empty or flushing; almost_empty port exists only with FIFO_READ_ALMOST_EMPTY_EN.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int PTR_WIDTH   = FIFO_PTR_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic                 w_clk,
  input  logic                 wresetn,
  input  logic                 flush,
  input  logic                 rd_enable,
  input  logic [PTR_WIDTH:0]   write_ptr_gray,
  output logic                 fifo_rd_enable,
  output logic [PTR_WIDTH-1:0] mem_rd_addr,
  output logic [PTR_WIDTH:0]   read_ptr,
  output logic [PTR_WIDTH:0]   read_ptr_gray,
  output logic                 empty,
  output logic                 rd_valid,
  output logic [PTR_WIDTH:0]   level
`ifdef FIFO_READ_ALMOST_EMPTY_EN
  ,
  output logic                 almost_empty
`endif
);

  localparam int PW1 = PTR_WIDTH + 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || DATA_WIDTH < 1 ||
      AE_LEVEL < 0 || AE_LEVEL > (1 << PTR_WIDTH)) begin : g_param_check
    $error("fifo_read_ctrl: illegal parameter combination");
  end

  logic [PTR_WIDTH:0] wq_gray;
  logic [PTR_WIDTH:0] wq_bin;
  logic [PTR_WIDTH:0] next_bin;
  logic [PTR_WIDTH:0] next_gray;
  logic [PTR_WIDTH:0] next_level;

  fifo_ptr_sync #(
    .WIDTH  (PW1),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .w_clk   (w_clk),
    .wresetn (wresetn),
    .d       (write_ptr_gray),
    .q       (wq_gray)
  );

  // Flags are computed against the post-update pointer so they match read_ptr after the edge.
  always_comb begin
    fifo_rd_enable = rd_enable & ~empty & ~flush;
    next_bin       = flush ? '0 : read_ptr + PW1'(fifo_rd_enable);
    next_gray      = PW1'(bin2gray(FIFO_GRAY_W'(next_bin)));
    wq_bin         = PW1'(gray2bin(FIFO_GRAY_W'(wq_gray)));
    next_level     = wq_bin - next_bin;
  end

  assign mem_rd_addr = read_ptr[PTR_WIDTH-1:0];

  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      read_ptr      <= '0;
      read_ptr_gray <= '0;
      empty         <= 1'b1;
      rd_valid      <= 1'b0;
      level         <= '0;
    end else begin
      read_ptr      <= next_bin;
      read_ptr_gray <= next_gray;
      empty         <= (next_gray == wq_gray);
      rd_valid      <= fifo_rd_enable;
      level         <= next_level;
    end
  end

`ifdef FIFO_READ_ALMOST_EMPTY_EN
  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      almost_empty <= 1'b1;
    end else begin
      almost_empty <= (next_level <= AE_LEVEL[PTR_WIDTH:0]);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with default parameters (PTR_WIDTH=4, SYNC_STAGES=2).
module tb_fifo_read_ctrl;

  logic       w_clk = 1'b0;
  logic       wresetn;
  logic       flush;
  logic       rd_enable;
  logic [4:0] write_ptr_gray;
  logic       fifo_rd_enable;
  logic [3:0] mem_rd_addr;
  logic [4:0] read_ptr;
  logic [4:0] read_ptr_gray;
  logic       empty;
  logic       rd_valid;
  logic [4:0] level;
`ifdef FIFO_READ_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_read_ctrl dut (
    .w_clk          (w_clk),
    .wresetn        (wresetn),
    .flush          (flush),
    .rd_enable      (rd_enable),
    .write_ptr_gray (write_ptr_gray),
    .fifo_rd_enable (fifo_rd_enable),
    .mem_rd_addr    (mem_rd_addr),
    .read_ptr       (read_ptr),
    .read_ptr_gray  (read_ptr_gray),
    .empty          (empty),
    .rd_valid       (rd_valid),
    .level          (level)
`ifdef FIFO_READ_ALMOST_EMPTY_EN
    ,
    .almost_empty   (almost_empty)
`endif
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    logic [4:0] wbin;
    logic [4:0] prev_ptr;
    logic       seen_wrap;
    logic [4:0] exp_lvl [4];
    logic       exp_ae  [4];

    wresetn        = 1'b0;
    flush          = 1'b0;
    rd_enable      = 1'b0;
    write_ptr_gray = '0;
    wbin           = '0;
    seen_wrap      = 1'b0;
    exp_lvl = '{5'd3, 5'd2, 5'd1, 5'd0};
    exp_ae  = '{1'b0, 1'b1, 1'b1, 1'b1};

    // Reset state
    tick(); tick();
    chk("rst_read_ptr", 32'(read_ptr), 32'd0);
    chk("rst_read_ptr_gray", 32'(read_ptr_gray), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
`ifdef FIFO_READ_ALMOST_EMPTY_EN
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
`endif
    wresetn = 1'b1;
    tick();

    // Latency: one word written, empty drops on the third edge
    wbin = 5'd1;
    write_ptr_gray = to_gray(wbin);
    tick();
    chk("lat_empty_e1", 32'(empty), 32'd1);
    tick();
    chk("lat_empty_e2", 32'(empty), 32'd1);
    tick();
    chk("lat_empty_e3", 32'(empty), 32'd0);
    chk("lat_level_e3", 32'(level), 32'd1);
    rd_enable = 1'b1;
    #1;
    chk("lat_fifo_rd_enable", 32'(fifo_rd_enable), 32'd1);
    chk("lat_mem_rd_addr", 32'(mem_rd_addr), 32'd0);
    tick();
    chk("lat_rd_valid", 32'(rd_valid), 32'd1);
    chk("lat_read_ptr", 32'(read_ptr), 32'd1);
    chk("lat_read_ptr_gray", 32'(read_ptr_gray), 32'd1);
    chk("lat_empty_after", 32'(empty), 32'd1);
    chk("lat_level_after", 32'(level), 32'd0);

    // Underflow: rd_enable held while empty
    for (int i = 0; i < 5; i++) begin
      chk("uf_fifo_rd_enable", 32'(fifo_rd_enable), 32'd0);
      tick();
      chk("uf_read_ptr", 32'(read_ptr), 32'd1);
      chk("uf_rd_valid", 32'(rd_valid), 32'd0);
    end

    // Wrap: 40 words streamed through with reads every cycle
    for (int i = 0; i < 48; i++) begin
      if (i < 40) begin
        wbin = wbin + 5'd1;
        write_ptr_gray = to_gray(wbin);
      end
      prev_ptr = read_ptr;
      tick();
      chk("wrap_ptr_step", 32'(read_ptr), 32'(5'(prev_ptr + 5'(rd_valid))));
      chk("wrap_gray", 32'(read_ptr_gray), 32'(to_gray(read_ptr)));
      chk("wrap_empty_vs_level", 32'(empty), 32'(level == 5'd0));
      if (prev_ptr == 5'd31 && read_ptr == 5'd0) seen_wrap = 1'b1;
    end
    chk("wrap_seen_31_to_0", 32'(seen_wrap), 32'd1);
    chk("wrap_final_ptr", 32'(read_ptr), 32'd9);
    chk("wrap_final_gray", 32'(read_ptr_gray), 32'd13);
    chk("wrap_final_empty", 32'(empty), 32'd1);

    // Flush and read in the same cycle with three words queued
    rd_enable = 1'b0;
    wbin = 5'd12;
    write_ptr_gray = to_gray(wbin);
    tick(); tick(); tick(); tick();
    chk("fl_level_pre", 32'(level), 32'd3);
    chk("fl_empty_pre", 32'(empty), 32'd0);
    flush = 1'b1;
    rd_enable = 1'b1;
    #1;
    chk("fl_fifo_rd_enable", 32'(fifo_rd_enable), 32'd0);
    tick();
    chk("fl_read_ptr", 32'(read_ptr), 32'd0);
    chk("fl_read_ptr_gray", 32'(read_ptr_gray), 32'd0);
    chk("fl_rd_valid", 32'(rd_valid), 32'd0);
    chk("fl_level_post", 32'(level), 32'd12);
    flush = 1'b0;
    rd_enable = 1'b0;

    // Level drain from 4 to 0 (almost_empty when built with the feature)
    wresetn = 1'b0;
    wbin = 5'd0;
    write_ptr_gray = '0;
    tick();
    wresetn = 1'b1;
    tick();
    wbin = 5'd4;
    write_ptr_gray = to_gray(wbin);
    tick(); tick(); tick();
    chk("ae_level_4", 32'(level), 32'd4);
`ifdef FIFO_READ_ALMOST_EMPTY_EN
    chk("ae_flag_4", 32'(almost_empty), 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      rd_enable = 1'b1;
      tick();
      rd_enable = 1'b0;
      chk("ae_level", 32'(level), 32'(exp_lvl[i]));
`ifdef FIFO_READ_ALMOST_EMPTY_EN
      chk("ae_flag", 32'(almost_empty), 32'(exp_ae[i]));
`else
      chk("ae_ptr", 32'(read_ptr), 32'(i + 1));
`endif
    end
    chk("ae_empty_end", 32'(empty), 32'd1);

    // Reset asserted while a read is in flight
    wbin = 5'd5;
    write_ptr_gray = to_gray(wbin);
    tick(); tick(); tick();
    chk("mr_empty_pre", 32'(empty), 32'd0);
    rd_enable = 1'b1;
    tick();
    chk("mr_rd_valid_pre", 32'(rd_valid), 32'd1);
    chk("mr_read_ptr_pre", 32'(read_ptr), 32'd5);
    #2;
    wresetn = 1'b0;
    #1;
    chk("mr_read_ptr", 32'(read_ptr), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_rd_valid", 32'(rd_valid), 32'd0);
    chk("mr_level", 32'(level), 32'd0);
    rd_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
